pb_debounce_multi: RTL and testbench
====================================

Name: pb_debounce_multi

Overview:
- Multi-channel push-button conditioner: per-channel synchroniser, debounce filter, debounced level, and one-cycle press/release strobes.
- Successor to the single-button release synchroniser. Adds parametrised channel count, synchroniser depth and debounce window, plus press-edge strobes.
- Sits between the board push-button pins and the command/control logic. All outputs are glitch-free and synchronous to clk.

Parameters:
- N_CH, 4: number of independent button channels (>=1).
- SYNC_STAGES, 2: synchroniser flop depth per channel (>=2).
- DB_CYCLES, 1000: consecutive stable cycles required to accept a new level (>=1).
- LONG_CYCLES, 50000000: hold cycles for a long-press strobe. Used only with LONG_PRESS_EN (>=1).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- PB  input  N_CH  raw, asynchronous, active-low buttons (1 = released)
- pressed  output  N_CH  debounced level, 1 = held
- press_pulse  output  N_CH  one-cycle strobe on accepted press
- released  output  N_CH  one-cycle strobe on accepted release
- long_pulse  output  N_CH  one-cycle long-press strobe (see Optional Feature)

Behaviour:
- Clocking and reset:
  - One clock: clk.
  - Reset: rst, synchronous, active-high, sampled on posedge clk only.
- Reset values:
  - All synchroniser flops = 1 (released).
  - Debounced state = 1.
  - Debounce and long counters = 0.
  - pressed = 0, press_pulse = 0, released = 0, long_pulse = 0.
  - No strobes fire in the first cycles after reset while PB is idle high.
- Per-channel path: PB[i] passes through a SYNC_STAGES flop chain to give s[i]. No combinational path from PB to any output.
- Debounce counter cnt[i], width $clog2(DB_CYCLES+1):
  - s[i] == db[i]: cnt <= 0.
  - s[i] != db[i] and cnt < DB_CYCLES-1: cnt <= cnt+1.
  - s[i] != db[i] and cnt == DB_CYCLES-1: db[i] <= s[i], cnt <= 0, and the matching strobe fires for the following cycle.
- Any single-cycle return of s to db restarts the count from 0. There is no partial credit.
- Strobes are registered and asserted in the same cycle db changes:
  - press_pulse[i] = 1 for exactly one cycle when db goes 1->0.
  - released[i] = 1 for exactly one cycle when db goes 0->1.
  - press_pulse[i] and released[i] are never high together.
- pressed[i] = ~db[i], registered.
- Latency: a clean PB edge held stable is reflected at the outputs exactly SYNC_STAGES+DB_CYCLES rising edges after the first edge that samples it.
- DB_CYCLES = 1: no filtering; latency = SYNC_STAGES+1.
- Channels are fully independent. Simultaneous edges on several channels produce simultaneous strobes.
- Reset mid-count: counters clear and db returns to 1 with no strobe. A button held through reset produces a press_pulse only after a full SYNC_STAGES+DB_CYCLES window.

Optional Feature:
- Macro: LONG_PRESS_EN.
- Defined:
  - Per-channel hold counter hc[i], width $clog2(LONG_CYCLES+1). Clears while db[i] = 1; increments each cycle db[i] = 0, saturating at LONG_CYCLES.
  - long_pulse[i] = 1 for exactly one cycle when hc transitions to LONG_CYCLES, i.e. LONG_CYCLES cycles after press_pulse[i].
  - Only one long_pulse per press. Release before LONG_CYCLES produces no long_pulse.
  - Reset clears hc.
- Not defined: long_pulse is tied to 0 and no hold counters are built. The port list is unchanged.

Test Plan (N_CH=2, SYNC_STAGES=2, DB_CYCLES=4, LONG_CYCLES=10):
- Reset hold: rst=1 for 3 cycles with PB=2'b11, then released -> all outputs 0 for 20 cycles.
- Clean press: PB[0] 1->0 and held -> press_pulse[0]=1 for one cycle, 6 edges after the first sampling edge; pressed[0]=1 thereafter; channel 1 stays quiet.
- Glitch: PB[0] low for 3 cycles, then high -> no press_pulse, pressed[0] stays 0. Same with a bounce pattern 0,0,0,1,0,0,0,0 -> press_pulse only after the final 4 stable cycles.
- Release: from pressed, PB[0] 0->1 held -> released[0]=1 for one cycle after 6 edges; pressed[0]=0.
- Simultaneous: PB=2'b11->2'b00 on the same edge -> press_pulse=2'b11 in the same cycle.
- Reset mid-count: PB[1] low, rst asserted at count 2 for 1 cycle, PB[1] still low -> no strobe during reset; press_pulse[1] 6 edges after rst deasserts.
- LONG_PRESS_EN defined: hold PB[0] low -> long_pulse[0] exactly 10 cycles after press_pulse[0], once only.
- LONG_PRESS_EN defined, short press: release after 8 cycles -> no long_pulse.
- LONG_PRESS_EN not defined: long_pulse stays 0 throughout.

Source files
------------

// File: rtl/pb_debounce_multi_if.sv
// Button-side bundle for pb_debounce_multi: raw active-low pins in, conditioned levels and strobes out.
interface pb_debounce_multi_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] PB;
    logic [N_CH-1:0] pressed;
    logic [N_CH-1:0] press_pulse;
    logic [N_CH-1:0] released;
    logic [N_CH-1:0] long_pulse;

    // Handshake: none. PB is a free-running level; every output is a registered level or a one-cycle strobe valid on each clk edge.
    modport master (
        output PB,
        input  pressed,
        input  press_pulse,
        input  released,
        input  long_pulse
    );

    modport slave (
        input  PB,
        output pressed,
        output press_pulse,
        output released,
        output long_pulse
    );
endinterface

// File: rtl/pb_debounce_multi.sv
// Multi-channel push-button conditioner: synchroniser, debounce filter, level and press/release strobes.
// Optional long-press strobe is built only when the LONG_PRESS_EN macro is defined.
module pb_debounce_multi #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 1000,
    parameter int LONG_CYCLES = 50000000
) (
    input  logic                clk,
    input  logic                rst,
    pb_debounce_multi_if.slave  btn_if
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    // Synchroniser chain, stage 0 samples the asynchronous pins.
    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] s_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '1;
            end
        end else begin
            sync_q[0] <= btn_if.PB;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s_w = sync_q[SYNC_STAGES-1];

    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]  db_q, db_d;
    logic [N_CH-1:0]  pressed_q, pressed_d;
    logic [N_CH-1:0]  press_q, press_d;
    logic [N_CH-1:0]  rel_q, rel_d;

    // Any sample matching the accepted level discards all progress toward a change.
    always_comb begin
        db_d    = db_q;
        press_d = '0;
        rel_d   = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s_w[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i]   = '0;
                db_d[i]    = s_w[i];
                press_d[i] = ~s_w[i];
                rel_d[i]   = s_w[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        pressed_d = ~db_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
            db_q      <= '1;
            pressed_q <= '0;
            press_q   <= '0;
            rel_q     <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            db_q      <= db_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            rel_q     <= rel_d;
        end
    end

    assign btn_if.pressed     = pressed_q;
    assign btn_if.press_pulse = press_q;
    assign btn_if.released    = rel_q;

`ifdef LONG_PRESS_EN
    localparam int HC_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES + 1) : 1;
    localparam logic [HC_W-1:0] HC_MAX = HC_W'(LONG_CYCLES);

    logic [HC_W-1:0] hc_q [N_CH];
    logic [HC_W-1:0] hc_d [N_CH];
    logic [N_CH-1:0] long_q, long_d;

    // Saturation keeps the strobe to a single firing per press.
    always_comb begin
        long_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (db_q[i]) begin
                hc_d[i] = '0;
            end else if (hc_q[i] == HC_MAX) begin
                hc_d[i] = hc_q[i];
            end else begin
                hc_d[i] = hc_q[i] + HC_W'(1);
            end
            long_d[i] = (hc_d[i] == HC_MAX) && (hc_q[i] != HC_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                hc_q[i] <= '0;
            end
            long_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                hc_q[i] <= hc_d[i];
            end
            long_q <= long_d;
        end
    end

    assign btn_if.long_pulse = long_q;
`else
    assign btn_if.long_pulse = '0;
`endif

endmodule

// File: tb/tb_pb_debounce_multi.sv
// Directed bench for pb_debounce_multi (N_CH=2, SYNC_STAGES=2, DB_CYCLES=4, LONG_CYCLES=10).
module tb_pb_debounce_multi;

  localparam int N_CH        = 2;
  localparam int SYNC_STAGES = 2;
  localparam int DB_CYCLES   = 4;
  localparam int LONG_CYCLES = 10;
  localparam int LAT         = SYNC_STAGES + DB_CYCLES;

`ifdef LONG_PRESS_EN
  localparam bit LONG_ON = 1'b1;
`else
  localparam bit LONG_ON = 1'b0;
`endif

  typedef struct {
    logic            rst;
    logic [N_CH-1:0] pb;
    logic [N_CH-1:0] exp_pressed;
    logic [N_CH-1:0] exp_press;
    logic [N_CH-1:0] exp_rel;
    logic [N_CH-1:0] exp_long;
  } vec_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  vec_t vq[$];

  pb_debounce_multi_if #(.N_CH(N_CH)) bus_if ();

  pb_debounce_multi #(
    .N_CH(N_CH),
    .SYNC_STAGES(SYNC_STAGES),
    .DB_CYCLES(DB_CYCLES),
    .LONG_CYCLES(LONG_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_if(bus_if.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic [N_CH-1:0] pb, input logic [N_CH-1:0] pr,
                              input logic [N_CH-1:0] pp, input logic [N_CH-1:0] rl,
                              input logic [N_CH-1:0] lp, input int n);
    vec_t v;
    v.rst = r; v.pb = pb; v.exp_pressed = pr; v.exp_press = pp; v.exp_rel = rl; v.exp_long = lp;
    for (int k = 0; k < n; k++) vq.push_back(v);
  endfunction

  // driver: one cycle, sampled 1 time unit after the edge
  task automatic step(input logic r, input logic [N_CH-1:0] pb);
    rst       = r;
    bus_if.PB = pb;
    @(posedge clk);
    #1;
  endtask

  // Count edges until the selected strobe on channel ch fires (kind 0 = press, 1 = release).
  task automatic wait_strobe(input int kind, input int ch, input int budget, output int n);
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      hit = (kind == 0) ? bus_if.press_pulse[ch] : bus_if.released[ch];
    end
  endtask

  initial begin
    logic [N_CH-1:0] l0;
    logic [N_CH-1:0] l1;
    logic [N_CH-1:0] l01;
    int n;
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    bus_if.PB = '1;
    l0  = LONG_ON ? 2'b01 : 2'b00;
    l1  = LONG_ON ? 2'b10 : 2'b00;
    l01 = LONG_ON ? 2'b11 : 2'b00;

    // reset hold, then idle
    add(1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 3);
    add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 20);
    // clean press on ch0, held long enough for a long-press strobe
    add(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, LAT - 1);
    add(0, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 1);
    add(0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, LONG_CYCLES - 1);
    add(0, 2'b10, 2'b01, 2'b00, 2'b00, l0,    1);
    add(0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 6);
    // release ch0
    add(0, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, LAT - 1);
    add(0, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 1);
    add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 5);
    // glitch: 3 low cycles only
    add(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 3);
    add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 8);
    // bounce 0,0,0,1 then stable low
    add(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 3);
    add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1);
    add(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, LAT - 1);
    add(0, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 1);
    // short press: debounced level low for 8 cycles, no long strobe
    add(0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2);
    add(0, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, LAT - 1);
    add(0, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 1);
    add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 10);
    // simultaneous press on both channels
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, LAT - 1);
    add(0, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 1);
    add(0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, LONG_CYCLES - 1);
    add(0, 2'b00, 2'b11, 2'b00, 2'b00, l01,   1);
    add(0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2);
    add(0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, LAT - 1);
    add(0, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 1);
    add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 3);
    // reset at count 2 on ch1
    add(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 4);
    add(1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1);
    add(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, LAT - 1);
    add(0, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 1);
    add(0, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, LONG_CYCLES - 1);
    add(0, 2'b01, 2'b10, 2'b00, 2'b00, l1,    1);
    add(0, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2);
    add(0, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, LAT - 1);
    add(0, 2'b11, 2'b00, 2'b00, 2'b10, 2'b00, 1);
    add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 3);

    for (int k = 0; k < vq.size(); k++) begin
      step(vq[k].rst, vq[k].pb);
      check($sformatf("vec%0d", k),
            {24'd0, bus_if.pressed, bus_if.press_pulse, bus_if.released, bus_if.long_pulse},
            {24'd0, vq[k].exp_pressed, vq[k].exp_press, vq[k].exp_rel, vq[k].exp_long});
      check($sformatf("excl%0d", k), {30'd0, bus_if.press_pulse & bus_if.released}, 32'd0);
    end

    // button held through reset: latency restarts from a full window
    step(0, 2'b10);
    wait_strobe(0, 0, 40, n);
    check("held_press_lat", n, LAT - 1);
    step(1, 2'b10);
    check("held_rst_outs", {24'd0, bus_if.pressed, bus_if.press_pulse, bus_if.released, bus_if.long_pulse}, 32'd0);
    rst = 1'b0;
    wait_strobe(0, 0, 40, n);
    check("held_after_rst_lat", n, LAT);
    check("held_pressed", {30'd0, bus_if.pressed}, 32'd1);
    bus_if.PB = 2'b11;
    wait_strobe(1, 0, 40, n);
    check("held_release_lat", n, LAT);
    check("held_released_lvl", {30'd0, bus_if.pressed}, 32'd0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
